// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Frame layout (LSB first on the wire): {stop, parity, data[7:0], start}.
package uart_pkg;

    localparam int DATA_W  = 8;
    localparam int FRAME_W = 11;

    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_ODD      = 2'b01;
    localparam logic [1:0] PAR_EVEN     = 2'b10;
    localparam logic [1:0] PAR_NONE_ALT = 2'b11;

    localparam logic [3:0] IDX_START  = 4'd0;
    localparam logic [3:0] IDX_DATA0  = 4'd1;
    localparam logic [3:0] IDX_PARITY = 4'd9;
    localparam logic [3:0] IDX_STOP   = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    function automatic logic parity_enabled(input logic [1:0] parity_type);
        return (parity_type == PAR_ODD) || (parity_type == PAR_EVEN);
    endfunction

endpackage

// File: rtl/frame_gen.sv
// Assembles the 11-bit serial frame from a byte and its parity bit.
// With parity disabled the parity slot reads as idle-high; the controller skips it anyway.
module frame_gen
    import uart_pkg::*;
(
    input  logic [DATA_W-1:0]  data,
    input  logic               parity_out,
    input  logic [1:0]         parity_type,
    output logic [FRAME_W-1:0] frame_out
);

    logic parity_slot;

    always_comb begin
        parity_slot = parity_enabled(parity_type) ? parity_out : 1'b1;
        frame_out   = {1'b1, parity_slot, data, 1'b0};
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: latches a byte and parity mode, then shifts one frame
// out LSB-first at CLKS_PER_BIT clocks per bit. All outputs are registered.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        parity_type,
    output logic              tx_out,
    output logic              tx_ready,
    output logic              tx_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t          state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [1:0]         par_q, par_d;
    logic               tx_out_q, tx_out_d;
    logic               tx_ready_q, tx_ready_d;
    logic               tx_done_q, tx_done_d;

    logic               baud_wrap;
    logic               accept;
    logic               parity_bit;
    logic [3:0]         frame_idx;
    logic [FRAME_W-1:0] frame;

    assign parity_bit = (par_q == PAR_ODD) ? ~^data_q : ^data_q;

    frame_gen u_frame_gen (
        .data        (data_q),
        .parity_out  (parity_bit),
        .parity_type (par_q),
        .frame_out   (frame)
    );

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        data_d    = data_q;
        par_d     = par_q;
        tx_done_d = 1'b0;
        accept    = 1'b0;
        baud_wrap = (baud_q == BAUD_LAST);

        if (state_q != ST_IDLE) begin
            baud_d = baud_wrap ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                accept = tx_start;
            end
            ST_START: begin
                if (baud_wrap) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (baud_wrap) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = parity_enabled(par_q) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_wrap) state_d = ST_STOP;
            end
            ST_STOP: begin
                // A request present as the stop bit ends chains the next frame with no idle gap.
                if (baud_wrap) begin
                    tx_done_d = 1'b1;
                    accept    = tx_start;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            state_d = ST_START;
            data_d  = data_in;
            par_d   = parity_type;
            baud_d  = '0;
            bit_d   = '0;
        end

        // The line level for the next cycle is selected from the frame by next state.
        case (state_d)
            ST_START:  frame_idx = IDX_START;
            ST_DATA:   frame_idx = IDX_DATA0 + {1'b0, bit_d};
            ST_PARITY: frame_idx = IDX_PARITY;
            ST_STOP:   frame_idx = IDX_STOP;
            default:   frame_idx = IDX_STOP;
        endcase

        tx_out_d   = (state_d == ST_IDLE) ? 1'b1 : frame[frame_idx];
        tx_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            data_q     <= '0;
            par_q      <= PAR_NONE;
            tx_out_q   <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            par_q      <= par_d;
            tx_out_q   <= tx_out_d;
            tx_ready_q <= tx_ready_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign tx_out   = tx_out_q;
    assign tx_ready = tx_ready_q;
    assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: a per-cycle waveform model (frame expanded into a queue of line
// levels) checked every cycle, plus hand-computed frame patterns for directed vectors.
module tb_uart_tx_ctrl;

    logic       clk;
    logic       rst;
    logic [1:0] tx_start;
    logic [7:0] data_in;
    logic [1:0] parity_type;
    logic [1:0] tx_out;
    logic [1:0] tx_ready;
    logic [1:0] tx_done;

    int n_checks;
    int n_fail;
    int sel;

    // Instance 0 runs at 4 clocks per bit, instance 1 at the minimum of 2.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        uart_tx_ctrl #(.CLKS_PER_BIT(g == 0 ? 4 : 2)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .tx_start    (tx_start[g]),
            .data_in     (data_in),
            .parity_type (parity_type),
            .tx_out      (tx_out[g]),
            .tx_ready    (tx_ready[g]),
            .tx_done     (tx_done[g])
        );
    end

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Model: exp_q holds the line level for the current and remaining cycles of a frame.
    logic exp_q[$];
    logic m_done;
    logic m_busy;

    function automatic void push_frame(input logic [7:0] d, input logic [1:0] pt, input int n);
        logic seq[$];
        int ones;
        ones = $countones(d);
        seq.push_back(1'b0);
        for (int i = 0; i < 8; i++) seq.push_back(d[i]);
        if (pt == 2'b01) seq.push_back((ones % 2) == 0);
        if (pt == 2'b10) seq.push_back((ones % 2) == 1);
        seq.push_back(1'b1);
        foreach (seq[i]) begin
            for (int r = 0; r < n; r++) exp_q.push_back(seq[i]);
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_done = 1'b0;
        end else begin
            m_busy = (exp_q.size() != 0);
            if (m_busy) void'(exp_q.pop_front());
            m_done = m_busy && (exp_q.size() == 0);
            if (exp_q.size() == 0 && tx_start[sel] == 1'b1) begin
                push_frame(data_in, parity_type, (sel == 1) ? 2 : 4);
            end
        end
    end

    always @(negedge clk) begin
        chk("model_tx_out",   {31'd0, tx_out[sel]},   {31'd0, (exp_q.size() != 0) ? exp_q[0] : 1'b1});
        chk("model_tx_ready", {31'd0, tx_ready[sel]}, {31'd0, exp_q.size() == 0});
        chk("model_tx_done",  {31'd0, tx_done[sel]},  {31'd0, m_done});
    end

    // Driver: send one frame and pin its bit pattern (index 0 = start bit) and done timing.
    task automatic pin_frame(input int s, input logic [7:0] d, input logic [1:0] pt,
                             input int nbits, input logic [10:0] exp, input bit disturb,
                             input string name);
        int n;
        int w;
        int r;
        logic [10:0] got;
        n = (s == 1) ? 2 : 4;
        got = '0;
        w = 0;
        while (tx_ready[s] !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) chk({name, "_ready_timeout"}, 32'd0, 32'd1);
        data_in = d;
        parity_type = pt;
        tx_start[s] = 1'b1;
        @(negedge clk);
        tx_start[s] = 1'b0;
        for (int c = 0; c < nbits * n; c++) begin
            if (c % n == 0) got[c / n] = tx_out[s];
            if (disturb && c >= 2 && c < nbits * n - 3 && (c % 5) == 0) begin
                r = $urandom_range(0, 255);
                tx_start[s] = 1'b1;
                data_in = r[7:0];
                parity_type = r[1:0];
            end else begin
                tx_start[s] = 1'b0;
            end
            @(negedge clk);
        end
        chk({name, "_bits"},  {21'd0, got}, {21'd0, exp});
        chk({name, "_done"},  {31'd0, tx_done[s]},  32'd1);
        chk({name, "_ready"}, {31'd0, tx_ready[s]}, 32'd1);
    endtask

    logic [19:0] got20;

    initial begin
        n_checks = 0;
        n_fail = 0;
        sel = 0;
        rst = 1'b1;
        tx_start = 2'b00;
        data_in = 8'h00;
        parity_type = 2'b00;

        // Reset held three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_tx_out",   {31'd0, tx_out[0]},   32'd1);
            chk("rst_tx_ready", {31'd0, tx_ready[0]}, 32'd1);
            chk("rst_tx_done",  {31'd0, tx_done[0]},  32'd0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        pin_frame(0, 8'hA5, 2'b00, 10, 11'h34A, 1'b0, "a5_none");
        pin_frame(0, 8'hA5, 2'b10, 11, 11'h54A, 1'b0, "a5_even");
        pin_frame(0, 8'hA5, 2'b01, 11, 11'h74A, 1'b0, "a5_odd");
        pin_frame(0, 8'h01, 2'b10, 11, 11'h602, 1'b0, "01_even");
        pin_frame(0, 8'hA5, 2'b11, 10, 11'h34A, 1'b0, "a5_none_alt");
        pin_frame(0, 8'h3C, 2'b00, 10, 11'h278, 1'b1, "3c_busy_pulses");

        // Back-to-back: tx_start held, data changes mid-frame to the second byte
        repeat (2) @(negedge clk);
        data_in = 8'h55;
        parity_type = 2'b00;
        tx_start[0] = 1'b1;
        @(negedge clk);
        got20 = '0;
        for (int c = 0; c < 80; c++) begin
            if (c % 4 == 0) got20[c / 4] = tx_out[0];
            if (c == 0) data_in = 8'h0F;
            if (c == 40) begin
                chk("b2b_gap_done",   {31'd0, tx_done[0]}, 32'd1);
                chk("b2b_gap_tx_out", {31'd0, tx_out[0]},  32'd0);
                tx_start[0] = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b_bits",  {12'd0, got20}, {12'd0, 10'h21E, 10'h2AA});
        chk("b2b_done",  {31'd0, tx_done[0]},  32'd1);
        chk("b2b_ready", {31'd0, tx_ready[0]}, 32'd1);

        // Reset during DATA bit 3 of 8'hFF
        repeat (2) @(negedge clk);
        data_in = 8'hFF;
        parity_type = 2'b00;
        tx_start[0] = 1'b1;
        @(negedge clk);
        tx_start[0] = 1'b0;
        repeat (17) @(negedge clk);
        chk("abort_busy", {31'd0, tx_ready[0]}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_tx_out",   {31'd0, tx_out[0]},   32'd1);
        chk("abort_tx_ready", {31'd0, tx_ready[0]}, 32'd1);
        chk("abort_tx_done",  {31'd0, tx_done[0]},  32'd0);
        pin_frame(0, 8'h00, 2'b00, 10, 11'h200, 1'b0, "after_abort_00");

        // Switch to the N=2 instance while both are idle
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 sel = 1;
        @(negedge clk);
        pin_frame(1, 8'h80, 2'b00, 10, 11'h300, 1'b0, "n2_80");
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller that sequences one serial frame per request. It latches a byte and parity mode, computes the parity bit, builds the frame through `frame_gen`, and shifts the frame out LSB-first at a fixed baud rate. It sits between the host-side byte interface and the `tx` pin, and owns all transmit timing.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range ≥ 2.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `tx_start` in 1: request; sampled only when `tx_ready`=1.
- `data_in` in 8: byte to send; sampled with `tx_start`.
- `parity_type` in 2: 00 none, 01 odd, 10 even, 11 none; sampled with `tx_start`.
- `tx_out` out 1: serial line; idles high.
- `tx_ready` out 1: high when in IDLE and able to accept `tx_start`.
- `tx_done` out 1: one-cycle pulse after the stop bit completes.

## Operation
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:**
  - `tx_out`=1, `tx_ready`=1.
  - If `tx_start`=1, latch `data_in` and `parity_type`, clear the baud and bit counters, and go to START.
- **START:** `tx_out`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA:**
  - `tx_out`=`data_q[bit_cnt]`, `bit_cnt` 0..7, each bit held `CLKS_PER_BIT` cycles.
  - After bit 7, go to PARITY if mode is 01/10, else go to STOP.
- **PARITY:** `tx_out` = parity bit for `CLKS_PER_BIT` cycles, then go to STOP.
  - Even parity: `^data_q`.
  - Odd parity: `~^data_q`.
- **STOP:** `tx_out`=1 for `CLKS_PER_BIT` cycles, then go to IDLE with `tx_done`=1 for that first IDLE cycle.
- **Frame contents:** taken from `frame_gen` output {stop, parity, data, start}. The controller indexes it by state and bit; bit 9 is skipped when there is no parity.
- **Counters:**
  - The baud counter is `$clog2(CLKS_PER_BIT)` bits wide, counts 0..`CLKS_PER_BIT`-1, and wraps to 0 on bit advance.
  - `bit_cnt` is 3 bits and advances only on baud wrap in DATA.
- **Boundary behaviour:**
  - `tx_start` while `tx_ready`=0 is ignored, not queued.
  - Changes on `data_in`/`parity_type` mid-frame have no effect.
  - `tx_start` during the `tx_done` cycle is accepted, giving back-to-back frames with zero idle gap.
  - `rst` mid-frame aborts the frame; at the next edge `tx_out`=1 and the FSM is in IDLE. No `tx_done` is generated for an aborted frame.
- **Reset values:** `tx_out`=1, `tx_ready`=1, `tx_done`=0, state IDLE, counters 0, `data_q`=0, parity latch 00.

## Timing
- `tx_start` is sampled at edge k. The start bit (`tx_out`=0) is visible from cycle k+1, a latency of 1 cycle. `tx_ready` drops in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Frame length:
  - No parity: 10·`CLKS_PER_BIT` cycles.
  - With parity: 11·`CLKS_PER_BIT` cycles.
- `tx_done` and `tx_ready` rise in the first cycle after the final stop-bit cycle. That is cycle k+1+10·N without parity, or k+1+11·N with parity, where N = `CLKS_PER_BIT`.
- Sustained throughput is one frame per 10·N or 11·N cycles when `tx_start` is held high.

## Structure
- **Package `uart_pkg`:**
  - `tx_state_t` enum.
  - Parity encodings `PAR_NONE`=2'b00, `PAR_ODD`=2'b01, `PAR_EVEN`=2'b10, `PAR_NONE_ALT`=2'b11.
  - `FRAME_W`=11, `DATA_W`=8.
- **Sub-module:** instantiates the existing `frame_gen` (data, parity_out, parity_type → frame_out). The parity computation and FSM stay local to `uart_tx_ctrl`.

## Test plan
- **Reset and idle:** N=4, `rst` held 3 cycles, `tx_start`=0 → `tx_out`=1, `tx_ready`=1, `tx_done`=0 throughout.
- **No parity:** N=4, data 8'hA5, parity 00 → `tx_out` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles). `tx_done` pulses at cycle 41, and `tx_ready` is high there.
- **Parity modes:** N=4, data 8'hA5 with parity 10 → parity bit 0; with 01 → 1. Data 8'h01 with parity 10 → 1. Each frame is 44 cycles, and parity 11 behaves exactly like 00.
- **Back-to-back and busy requests:** N=4, `tx_start` held high with 8'h55 then 8'h0F → second start bit begins in the `tx_done` cycle with no idle high cycle. Pulses of `tx_start` and `data_in` changes mid-frame do not alter the frame.
- **Reset mid-frame:** N=4, data 8'hFF, `rst` asserted during DATA bit 3 → `tx_out`=1 and `tx_ready`=1 at the next edge, with no `tx_done`. A following request for 8'h00 transmits cleanly.
- **Divider corner:** N=2, data 8'h80, no parity → 20-cycle frame with bit 7 = 1 on cycles 17-18 after start, confirming baud counter wrap at the minimum N.
